snake_body_store: RTL and testbench

Parametrised snake position store and move engine for the VGA snake game. It holds head and body coordinates in a circular buffer of up to 2^LENGTH_BIT segments and advances the snake one cell per step pulse. Each step applies a grow request, grid wrap or wall mode, and a sequential self-collision scan. A zero-latency-arbitration read port by segment index serves the graphics renderer in the 25 MHz pixel domain.

---
 rtl/snake_pkg.sv | 23 ++
 rtl/snake_body_store_if.sv | 33 +++
 rtl/snake_next_head.sv | 41 ++++
 rtl/snake_body_store.sv | 130 +++++++++++++
 tb/tb_snake_body_store.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared heading and move-state types for the snake body store
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2,
        HIT    = 2'd3
    } state_t;

    // Opposite headings share the axis bit and differ only in the low bit.
    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'({d[1], ~d[0]});
    endfunction

endpackage

// File: rtl/snake_body_store_if.sv
// rtl/snake_body_store_if.sv - control, status and renderer read bus of the snake body store
interface snake_body_store_if #(
    parameter int COORD_BIT  = 7,
    parameter int LENGTH_BIT = 4
);
    logic                  clear;
    logic                  step;
    logic [1:0]            dir;
    logic                  grow;
    logic                  wrap_mode;
    logic [LENGTH_BIT-1:0] rd_index;
    logic [COORD_BIT-1:0]  rd_x;
    logic [COORD_BIT-1:0]  rd_y;
    logic                  rd_valid;
    logic [COORD_BIT-1:0]  head_x;
    logic [COORD_BIT-1:0]  head_y;
    // One extra bit so that a completely full buffer has a representable count.
    logic [LENGTH_BIT:0]   snake_length;
    logic                  busy;
    logic                  done;
    logic                  collision;
    logic                  full;

    modport master (
        output clear, step, dir, grow, wrap_mode, rd_index,
        input  rd_x, rd_y, rd_valid, head_x, head_y, snake_length, busy, done, collision, full
    );

    modport slave (
        input  clear, step, dir, grow, wrap_mode, rd_index,
        output rd_x, rd_y, rd_valid, head_x, head_y, snake_length, busy, done, collision, full
    );
endinterface

// File: rtl/snake_next_head.sv
// rtl/snake_next_head.sv - candidate head cell one step along the heading, with wrap or wall detect
module snake_next_head
    import snake_pkg::*;
#(
    parameter int COORD_BIT = 7,
    parameter int GRID_W    = 80,
    parameter int GRID_H    = 60
) (
    input  logic [COORD_BIT-1:0] head_x,
    input  logic [COORD_BIT-1:0] head_y,
    input  dir_t                 heading,
    input  logic                 wrap_mode,
    output logic [COORD_BIT-1:0] next_x,
    output logic [COORD_BIT-1:0] next_y,
    output logic                 wall_hit
);
    localparam logic [COORD_BIT-1:0] ONE   = COORD_BIT'(1);
    localparam logic [COORD_BIT-1:0] X_MAX = COORD_BIT'(GRID_W - 1);
    localparam logic [COORD_BIT-1:0] Y_MAX = COORD_BIT'(GRID_H - 1);

    always_comb begin
        next_x   = head_x;
        next_y   = head_y;
        wall_hit = 1'b0;
        case (heading)
            DIR_UP:
                if (head_y == '0) begin next_y = Y_MAX; wall_hit = !wrap_mode; end
                else next_y = head_y - ONE;
            DIR_DOWN:
                if (head_y == Y_MAX) begin next_y = '0; wall_hit = !wrap_mode; end
                else next_y = head_y + ONE;
            DIR_LEFT:
                if (head_x == '0) begin next_x = X_MAX; wall_hit = !wrap_mode; end
                else next_x = head_x - ONE;
            DIR_RIGHT:
                if (head_x == X_MAX) begin next_x = '0; wall_hit = !wrap_mode; end
                else next_x = head_x + ONE;
            default: wall_hit = 1'b0;
        endcase
    end
endmodule

// File: rtl/snake_body_store.sv
// rtl/snake_body_store.sv - circular segment store, sequential self-collision move engine, renderer read port
module snake_body_store
    import snake_pkg::*;
#(
    parameter int COORD_BIT   = 7,
    parameter int LENGTH_BIT  = 4,
    parameter int GRID_W      = 80,
    parameter int GRID_H      = 60,
    parameter int INIT_X      = 20,
    parameter int INIT_Y      = 15,
    parameter int INIT_LENGTH = 3
) (
    input logic               clock_25,
    input logic               reset,
    snake_body_store_if.slave bus
);
    localparam int DEPTH = 1 << LENGTH_BIT;
    localparam int LW    = LENGTH_BIT + 1;

    logic [COORD_BIT-1:0]  mem_x [DEPTH];
    logic [COORD_BIT-1:0]  mem_y [DEPTH];
    logic [LENGTH_BIT-1:0] head_ptr, new_ptr, scan_idx, scan_last, scan_ptr, rd_ptr;
    logic [LW-1:0]         length;
    logic [COORD_BIT-1:0]  cand_x, cand_y, next_x, next_y, rd_x, rd_y;
    logic                  wall_hit, grow_eff, grow_now, full, rd_hit;
    logic                  busy, done, collision, rd_valid;
    dir_t                  heading, move_dir;
    state_t                state;

    assign full     = (length == LW'(DEPTH));
    assign grow_now = bus.grow && !full;
    assign new_ptr  = head_ptr - LENGTH_BIT'(1);
    assign scan_ptr = head_ptr + scan_idx;
    assign rd_ptr   = head_ptr + bus.rd_index;
    assign rd_hit   = ({1'b0, bus.rd_index} < length);
    assign move_dir = (dir_t'(bus.dir) == reverse_dir(heading)) ? heading : dir_t'(bus.dir);

    snake_next_head #(.COORD_BIT(COORD_BIT), .GRID_W(GRID_W), .GRID_H(GRID_H)) u_next_head (
        .head_x(mem_x[head_ptr]), .head_y(mem_y[head_ptr]), .heading(move_dir),
        .wrap_mode(bus.wrap_mode), .next_x(next_x), .next_y(next_y), .wall_hit(wall_hit)
    );

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state <= IDLE;  heading <= DIR_RIGHT;  head_ptr <= '0;  length <= LW'(INIT_LENGTH);
            busy  <= 1'b0;  done <= 1'b0;  collision <= 1'b0;  grow_eff <= 1'b0;
            cand_x <= '0;  cand_y <= '0;  scan_idx <= '0;  scan_last <= '0;
        end else if (bus.clear) begin
            state <= IDLE;  heading <= DIR_RIGHT;  head_ptr <= '0;  length <= LW'(INIT_LENGTH);
            busy  <= 1'b0;  done <= 1'b0;  collision <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (bus.step && !collision) begin
                    heading <= move_dir;
                    busy    <= 1'b1;
                    if (wall_hit) state <= HIT;
                    else begin
                        cand_x    <= next_x;
                        cand_y    <= next_y;
                        grow_eff  <= grow_now;
                        scan_idx  <= '0;
                        // Without growth the tail cell is vacated, so it is excluded from the scan.
                        scan_last <= grow_now ? LENGTH_BIT'(length - LW'(1)) : LENGTH_BIT'(length - LW'(2));
                        state     <= SCAN;
                    end
                end
                SCAN:
                    if (mem_x[scan_ptr] == cand_x && mem_y[scan_ptr] == cand_y) state <= HIT;
                    else if (scan_idx == scan_last) begin
                        state <= COMMIT;
                        done  <= 1'b1;
                    end else scan_idx <= scan_idx + LENGTH_BIT'(1);
                COMMIT: begin
                    head_ptr <= new_ptr;
                    if (grow_eff) length <= length + LW'(1);
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                HIT: begin
                    collision <= 1'b1;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_x[k] <= COORD_BIT'(INIT_X - k);
                mem_y[k] <= COORD_BIT'(INIT_Y);
            end
        end else if (bus.clear) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_x[k] <= COORD_BIT'(INIT_X - k);
                mem_y[k] <= COORD_BIT'(INIT_Y);
            end
        end else if (state == COMMIT) begin
            mem_x[new_ptr] <= cand_x;
            mem_y[new_ptr] <= cand_y;
        end
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            rd_valid <= 1'b0;  rd_x <= '0;  rd_y <= '0;
        end else if (bus.clear) begin
            rd_valid <= 1'b0;  rd_x <= '0;  rd_y <= '0;
        end else begin
            rd_valid <= rd_hit;
            rd_x     <= rd_hit ? mem_x[rd_ptr] : '0;
            rd_y     <= rd_hit ? mem_y[rd_ptr] : '0;
        end
    end

    assign bus.rd_x         = rd_x;
    assign bus.rd_y         = rd_y;
    assign bus.rd_valid     = rd_valid;
    assign bus.head_x       = mem_x[head_ptr];
    assign bus.head_y       = mem_y[head_ptr];
    assign bus.snake_length = length;
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.collision    = collision;
    assign bus.full         = full;
endmodule

// File: tb/tb_snake_body_store.sv
// tb/tb_snake_body_store.sv - table, directed and randomised checks of snake_body_store against a queue model
module tb_snake_body_store;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    snake_body_store_if #(.COORD_BIT(7), .LENGTH_BIT(4)) b ();
    snake_body_store_if #(.COORD_BIT(7), .LENGTH_BIT(2)) s ();

    snake_body_store dut (.clock_25(clk), .reset(rst_n), .bus(b.slave));
    snake_body_store #(.LENGTH_BIT(2), .INIT_LENGTH(2)) dut_small (.clock_25(clk), .reset(rst_n), .bus(s.slave));

    localparam int NO_DONE = 40;

    int n_tests = 0;
    int n_fail  = 0;

    int mx[$];
    int my[$];
    int m_dir;
    bit m_coll;
    int dx[4] = '{0, 0, -1, 1};
    int dy[4] = '{-1, 1, 0, 0};

    typedef struct {
        bit clr; int d; bit g; bit w;
        int ex; int ey; int elen; int elat; bit ecoll;
    } vec_t;
    vec_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        mx.delete();
        my.delete();
        for (int k = 0; k < 3; k++) begin
            mx.push_back(20 - k);
            my.push_back(15);
        end
        m_dir  = 3;
        m_coll = 1'b0;
    endfunction

    // Edges from the step edge until done is seen, or NO_DONE when the step must be ignored.
    function automatic int model_step(input int d, input bit g, input bit w);
        int nx, ny, n;
        bit ge;
        if (m_coll) return NO_DONE;
        if (!(dx[d] == -dx[m_dir] && dy[d] == -dy[m_dir])) m_dir = d;
        nx = mx[0] + dx[m_dir];
        ny = my[0] + dy[m_dir];
        if (nx < 0 || nx >= 80 || ny < 0 || ny >= 60) begin
            if (!w) begin
                m_coll = 1'b1;
                return 1;
            end
            nx = (nx + 80) % 80;
            ny = (ny + 60) % 60;
        end
        ge = g && (mx.size() < 16);
        n  = ge ? mx.size() : mx.size() - 1;
        for (int j = 0; j < n; j++)
            if (mx[j] == nx && my[j] == ny) begin
                m_coll = 1'b1;
                return j + 2;
            end
        mx.push_front(nx);
        my.push_front(ny);
        if (!ge) begin
            void'(mx.pop_back());
            void'(my.pop_back());
        end
        return n;
    endfunction

    task automatic check_state();
        check("busy", b.busy, 0);
        check("collision", b.collision, m_coll);
        check("length", b.snake_length, mx.size());
        check("full", b.full, mx.size() == 16);
        check("head_x", b.head_x, mx[0]);
        check("head_y", b.head_y, my[0]);
        for (int k = 0; k < 16; k++) begin
            b.rd_index = 4'(k);
            tick();
            check($sformatf("rd_valid[%0d]", k), b.rd_valid, k < mx.size());
            check($sformatf("rd_x[%0d]", k), b.rd_x, (k < mx.size()) ? mx[k] : 0);
            check($sformatf("rd_y[%0d]", k), b.rd_y, (k < mx.size()) ? my[k] : 0);
        end
    endtask

    task automatic do_clear();
        b.clear = 1'b1;
        tick();
        b.clear = 1'b0;
        model_reset();
    endtask

    task automatic do_step(input int d, input bit g, input bit w, output int lat);
        int exp_lat;
        exp_lat = model_step(d, g, w);
        b.dir = 2'(d); b.grow = g; b.wrap_mode = w; b.step = 1'b1;
        tick();
        b.step = 1'b0; b.grow = 1'b0;
        lat = 0;
        while (!b.done && lat < NO_DONE) begin
            tick();
            lat++;
        end
        check("done latency", lat, exp_lat);
        tick();
        check_state();
    endtask

    task automatic step_small(input bit g, output int lat);
        s.dir = 2'd3; s.grow = g; s.step = 1'b1;
        tick();
        s.step = 1'b0; s.grow = 1'b0;
        lat = 0;
        while (!s.done && lat < NO_DONE) begin
            tick();
            lat++;
        end
        tick();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit seen_done;
        int s_lat[4] = '{2, 3, 3, 3};
        int s_len[4] = '{3, 4, 4, 4};

        b.clear = 0; b.step = 0; b.dir = 0; b.grow = 0; b.wrap_mode = 1; b.rd_index = 0;
        s.clear = 0; s.step = 0; s.dir = 0; s.grow = 0; s.wrap_mode = 1; s.rd_index = 0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("reset busy", b.busy, 0);
        check("reset done", b.done, 0);
        check("reset collision", b.collision, 0);
        check("reset rd_valid", b.rd_valid, 0);
        check("reset rd_x", b.rd_x, 0);
        check("reset rd_y", b.rd_y, 0);
        check("reset length", b.snake_length, 3);
        check("reset head_x", b.head_x, 20);
        check("reset head_y", b.head_y, 15);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b.rd_index = 4'(k);
            tick();
            check("init rd_valid", b.rd_valid, k < 3);
            check("init rd_x", b.rd_x, (k < 3) ? 20 - k : 0);
            check("init rd_y", b.rd_y, (k < 3) ? 15 : 0);
        end

        tbl.push_back('{1, 3, 0, 1, 21, 15, 3, 2, 0});
        tbl.push_back('{0, 2, 0, 1, 22, 15, 3, 2, 0});
        tbl.push_back('{0, 3, 1, 1, 23, 15, 4, 3, 0});
        tbl.push_back('{0, 3, 1, 1, 24, 15, 5, 4, 0});
        tbl.push_back('{0, 0, 0, 1, 24, 14, 5, 4, 0});
        tbl.push_back('{0, 2, 0, 1, 23, 14, 5, 4, 0});
        tbl.push_back('{0, 1, 0, 1, 23, 14, 5, 5, 1});
        tbl.push_back('{0, 3, 0, 1, 23, 14, 5, NO_DONE, 1});
        tbl.push_back('{1, 3, 1, 1, 21, 15, 4, 3, 0});
        tbl.push_back('{0, 0, 0, 1, 21, 14, 4, 3, 0});
        tbl.push_back('{0, 2, 0, 1, 20, 14, 4, 3, 0});
        tbl.push_back('{0, 1, 0, 1, 20, 15, 4, 3, 0});
        foreach (tbl[i]) begin
            if (tbl[i].clr) do_clear();
            do_step(tbl[i].d, tbl[i].g, tbl[i].w, lat);
            check($sformatf("tbl%0d latency", i), lat, tbl[i].elat);
            check($sformatf("tbl%0d head_x", i), b.head_x, tbl[i].ex);
            check($sformatf("tbl%0d head_y", i), b.head_y, tbl[i].ey);
            check($sformatf("tbl%0d length", i), b.snake_length, tbl[i].elen);
            check($sformatf("tbl%0d collision", i), b.collision, tbl[i].ecoll);
        end

        do_clear();
        for (int i = 0; i < 59; i++) do_step(3, 0, 1, lat);
        check("edge head_x", b.head_x, 79);
        do_step(3, 0, 1, lat);
        check("wrap head_x", b.head_x, 0);
        check("wrap collision", b.collision, 0);
        do_clear();
        for (int i = 0; i < 59; i++) do_step(3, 0, 0, lat);
        do_step(3, 0, 0, lat);
        check("wall latency", lat, 1);
        check("wall collision", b.collision, 1);
        check("wall head_x", b.head_x, 79);
        do_step(1, 0, 0, lat);
        check("dropped latency", lat, NO_DONE);
        check("dropped head_y", b.head_y, 15);

        for (int i = 0; i < 4; i++) begin
            step_small(1'b1, lat);
            check("small latency", lat, s_lat[i]);
            check("small length", s.snake_length, s_len[i]);
            check("small full", s.full, i > 0);
            check("small head_x", s.head_x, 21 + i);
        end
        s.rd_index = 2'd3;
        tick();
        check("small tail valid", s.rd_valid, 1);
        check("small tail x", s.rd_x, 21);
        s.dir = 2'd3; s.step = 1'b1;
        tick();
        s.step = 1'b0;
        check("small busy in scan", s.busy, 1);
        seen_done = s.done;
        tick();
        seen_done |= s.done;
        s.clear = 1'b1;
        tick();
        s.clear = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen_done |= s.done;
            tick();
        end
        check("abort no done", seen_done, 0);
        check("abort length", s.snake_length, 2);
        check("abort head_x", s.head_x, 20);
        check("abort head_y", s.head_y, 15);
        check("abort busy", s.busy, 0);
        check("abort full", s.full, 0);
        check("abort collision", s.collision, 0);

        do_clear();
        for (int i = 0; i < 150; i++) begin
            do_step($urandom_range(0, 3), $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, lat);
            if (m_coll && $urandom_range(0, 1) == 1) do_clear();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
